// File: rtl/addsub_serial_if.sv
// ---------------------------------------------------------------------------
// addsub_serial_if
//   Operand/result bundle for the digit-serial adder/subtractor.
//
//   Handshake: a transfer happens on a rising clk edge where valid and ready
//   are both high. A producer may raise valid at any time. The consumer's
//   ready may depend on its own state only. Data is sampled on the transfer
//   edge and may change freely afterwards.
//
//   Signals
//     in_valid  producer -> block  X, Y, sub are valid
//     in_ready  block -> producer  block can accept an operation
//     X, Y      producer -> block  operands (WIDTH bits)
//     sub       producer -> block  0: X+Y, 1: X-Y
//     out_valid block -> consumer  Z and flags are valid
//     out_ready consumer -> block  consumer takes the result
//     Z         block -> consumer  result modulo 2^WIDTH
//     cout      block -> consumer  carry out of MSB (subtract: 1 = no borrow)
//     ovf       block -> consumer  two's-complement overflow
//     zero      block -> consumer  Z == 0
//
//   Modports: master = operand producer / result consumer, slave = the block.
// ---------------------------------------------------------------------------
interface addsub_serial_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Z;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, X, Y, sub, out_ready,
        input  in_ready, out_valid, Z, cout, ovf, zero
    );

    modport slave (
        input  in_valid, X, Y, sub, out_ready,
        output in_ready, out_valid, Z, cout, ovf, zero
    );
endinterface

// File: rtl/addsub_serial.sv
// ---------------------------------------------------------------------------
// addsub_serial
//   Multi-cycle adder/subtractor. Operands are consumed DIGIT bits per clock
//   through a single DIGIT-bit adder slice, so a result takes WIDTH/DIGIT
//   clocks. Subtraction is X + ~Y + 1 (carry-in seeded with 1).
//
//   Ports
//     clk      in   rising-edge clock
//     rst      in   synchronous, active-high reset
//     bus      slave modport of addsub_serial_if (operands, result, flags)
//     state_o  out  current FSM state (0 IDLE, 1 RUN, 2 DONE) for observation
//
//   Parameters
//     WIDTH  operand/result width (>= 2)
//     DIGIT  bits processed per clock; must divide WIDTH
// ---------------------------------------------------------------------------
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    addsub_serial_if.slave       bus,
    output logic [1:0]           state_o
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_param_err
        $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  z_q;
    logic              carry_q;
    logic [CW-1:0]     cnt_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              cout_q;
    logic              ovf_q;
    logic              zero_q;

    // One digit slice: low DIGIT bits of A and B plus the running carry.
    logic [DIGIT:0]       sum_d;
    logic [WIDTH+DIGIT-1:0] z_cat_d;
    logic [WIDTH-1:0]     z_shift_d;
    logic                 msb_cin_d;
    logic                 last_d;

    always_comb begin
        sum_d     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry_q};
        // New digit enters at the MSB end; after NDIG steps the first digit
        // has reached bit 0. Concatenation keeps this legal when DIGIT==WIDTH.
        z_cat_d   = {sum_d[DIGIT-1:0], z_q};
        z_shift_d = z_cat_d[WIDTH+DIGIT-1:DIGIT];
        // Carry into the top bit of the slice: on the last digit this is the
        // carry into bit WIDTH-1, recovered from that bit's sum = a ^ b ^ cin.
        msb_cin_d = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ sum_d[DIGIT-1];
        last_d    = (cnt_q == CW'(NDIG - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            z_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.X;
                        b_q        <= bus.sub ? ~bus.Y : bus.Y;
                        carry_q    <= bus.sub;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    z_q     <= z_shift_d;
                    carry_q <= sum_d[DIGIT];
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_d) begin
                        cout_q      <= sum_d[DIGIT];
                        ovf_q       <= msb_cin_d ^ sum_d[DIGIT];
                        zero_q      <= (z_shift_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Z         = z_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_addsub_serial.sv
// ---------------------------------------------------------------------------
// tb_addsub_serial
//   Directed and random checking of addsub_serial. One 8-bit/2-digit instance
//   takes directed scenarios (latency, stall, ignored inputs, reset abort);
//   three further configurations run random back-to-back traffic. Expected
//   results come from an arithmetic model (unsigned compare for borrow, sign
//   rules for overflow) pushed into per-instance queues and popped by
//   monitors on each output transfer.
// ---------------------------------------------------------------------------
module tb_addsub_serial;
    localparam int NOPS = 1000;
    localparam int NCFG = 3;
    localparam int CFG_W [NCFG] = '{16, 16, 12};
    localparam int CFG_D [NCFG] = '{1, 16, 4};

    logic clk = 1'b0;
    logic rst8;
    logic rst_r;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // ---------------- reference model and helpers ----------------
    // Result packed as {zero, ovf, cout, Z[63:0]}.
    function automatic logic [66:0] ref_op(int w, logic [63:0] x_in,
                                           logic [63:0] y_in, logic s);
        logic [63:0] mask, x, y, z;
        logic [64:0] full;
        logic        c, o, sx, sy, sz;
        mask = (64'd1 << w) - 64'd1;
        x = x_in & mask;
        y = y_in & mask;
        full = '0;
        if (s) begin
            z = (x - y) & mask;
            c = (x >= y);
        end else begin
            full = {1'b0, x} + {1'b0, y};
            z = full[63:0] & mask;
            c = ((full >> w) != 65'd0);
        end
        sx = x[w-1];
        sy = y[w-1];
        sz = z[w-1];
        o  = s ? ((sx != sy) && (sz != sx)) : ((sx == sy) && (sz != sx));
        return {(z == 64'd0), o, c, z};
    endfunction

    function automatic logic [63:0] pick(int w);
        logic [63:0] mask;
        logic [63:0] r;
        mask = (64'd1 << w) - 64'd1;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return mask;
            2:       return 64'd1 << (w - 1);
            3:       return mask >> 1;
            default: return r & mask;
        endcase
    endfunction

    task automatic check_eq(string name, logic [66:0] act, logic [66:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- directed instance: WIDTH=8, DIGIT=2 ----------------
    addsub_serial_if #(.WIDTH(8)) b8();
    logic [1:0] st8;
    logic [66:0] exp8_q[$];

    addsub_serial #(.WIDTH(8), .DIGIT(2)) u8 (
        .clk    (clk),
        .rst    (rst8),
        .bus    (b8),
        .state_o(st8)
    );

    always @(negedge clk) begin
        if (b8.out_valid && b8.out_ready) begin
            if (exp8_q.size() == 0) begin
                check_eq("w8_unexpected_output", {1'b1, 66'd0}, 67'd0);
            end else begin
                check_eq("w8_result", {b8.zero, b8.ovf, b8.cout, 56'd0, b8.Z},
                         exp8_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [7:0] x, input logic [7:0] y,
                         input logic s, input bit push);
        int n;
        n = 0;
        b8.X = x;
        b8.Y = y;
        b8.sub = s;
        b8.in_valid = 1'b1;
        @(negedge clk);
        while (!b8.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_ready", 67'(b8.in_ready), 67'd1);
        if (push) exp8_q.push_back(ref_op(8, 64'(x), 64'(y), s));
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0;
        b8.X = 8'($urandom);
        b8.Y = 8'($urandom);
        b8.sub = 1'($urandom);
    endtask

    // Counts edges after the accepting edge until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 0;
        @(negedge clk);
        while (!b8.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // ---------------- random instances ----------------
    for (genvar g = 0; g < NCFG; g++) begin : g_rnd
        localparam int W = CFG_W[g];
        localparam int D = CFG_D[g];
        addsub_serial_if #(.WIDTH(W)) bus();
        logic [1:0]  st;
        logic [66:0] exp_q[$];
        int          got = 0;

        addsub_serial #(.WIDTH(W), .DIGIT(D)) dut (
            .clk    (clk),
            .rst    (rst_r),
            .bus    (bus),
            .state_o(st)
        );

        initial begin : drv
            int sent;
            logic [63:0] t;
            sent = 0;
            bus.in_valid = 1'b0;
            bus.X = '0;
            bus.Y = '0;
            bus.sub = 1'b0;
            bus.out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            while (sent < NOPS) begin
                bus.in_valid = ($urandom_range(0, 7) != 0);
                t = pick(W);
                bus.X = t[W-1:0];
                t = pick(W);
                bus.Y = t[W-1:0];
                bus.sub = 1'($urandom_range(0, 1));
                bus.out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(ref_op(W, 64'(bus.X), 64'(bus.Y), bus.sub));
                    sent++;
                end
                @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
        end

        always @(negedge clk) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq($sformatf("w%0d_d%0d_unexpected_output", W, D),
                             {1'b1, 66'd0}, 67'd0);
                end else begin
                    check_eq($sformatf("w%0d_d%0d_result", W, D),
                             {bus.zero, bus.ovf, bus.cout, 64'(bus.Z)},
                             exp_q.pop_front());
                end
                got++;
            end
        end
    end

    // ---------------- main sequence ----------------
    localparam int NDIR = 6;
    logic [7:0] dir_x [NDIR] = '{8'h5A, 8'hFF, 8'h7F, 8'h10, 8'h80, 8'hA5};
    logic [7:0] dir_y [NDIR] = '{8'h3C, 8'h01, 8'h01, 8'h20, 8'h01, 8'hA5};
    logic       dir_s [NDIR] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        int lat;
        int cyc;
        logic [66:0] hold_exp;

        rst8 = 1'b1;
        rst_r = 1'b1;
        b8.in_valid = 1'b0;
        b8.X = '0;
        b8.Y = '0;
        b8.sub = 1'b0;
        b8.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_r = 1'b0;
        b8.in_valid = 1'b1;   // ignored while in reset
        @(negedge clk);
        check_eq("rst_in_ready",  67'(b8.in_ready),  67'd1);
        check_eq("rst_out_valid", 67'(b8.out_valid), 67'd0);
        check_eq("rst_outputs",   {b8.zero, b8.ovf, b8.cout, 56'd0, b8.Z}, 67'd0);
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0;
        rst8 = 1'b0;

        // Directed vectors: add/sub corner cases, latency 4 edges.
        for (int i = 0; i < NDIR; i++) begin
            issue(dir_x[i], dir_y[i], dir_s[i], 1'b1);
            wait_out(lat);
            check_eq($sformatf("latency_dir%0d", i), 67'(lat), 67'd4);
            @(posedge clk);
            #1;
        end

        // Short random burst on the 8-bit instance.
        for (int i = 0; i < 20; i++) begin
            issue(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
            wait_out(lat);
            check_eq("latency_rnd8", 67'(lat), 67'd4);
            @(posedge clk);
            #1;
        end

        // Stall in DONE with in_valid noise during RUN and DONE.
        b8.out_ready = 1'b0;
        issue(8'hC3, 8'h4E, 1'b0, 1'b1);
        b8.in_valid = 1'b1;
        wait_out(lat);
        check_eq("latency_stall", 67'(lat), 67'd4);
        hold_exp = ref_op(8, 64'h0C3, 64'h04E, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            b8.in_valid = ~b8.in_valid;
            b8.X = 8'($urandom);
            b8.Y = 8'($urandom);
            b8.sub = 1'($urandom);
            @(negedge clk);
            check_eq("hold_result", {b8.zero, b8.ovf, b8.cout, 56'd0, b8.Z}, hold_exp);
            check_eq("hold_in_ready",  67'(b8.in_ready),  67'd0);
            check_eq("hold_out_valid", 67'(b8.out_valid), 67'd1);
        end
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0;
        b8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("post_hs_in_ready",  67'(b8.in_ready),  67'd1);
        check_eq("post_hs_out_valid", 67'(b8.out_valid), 67'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("no_extra_op", 67'(b8.out_valid), 67'd0);
        end

        // Reset on the second RUN cycle aborts the operation.
        @(posedge clk);
        #1;
        issue(8'h33, 8'h44, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst8 = 1'b1;
        @(posedge clk);
        #1;
        rst8 = 1'b0;
        @(negedge clk);
        check_eq("abort_in_ready",  67'(b8.in_ready),  67'd1);
        check_eq("abort_out_valid", 67'(b8.out_valid), 67'd0);
        check_eq("abort_outputs",   {b8.zero, b8.ovf, b8.cout, 56'd0, b8.Z}, 67'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("abort_no_valid", 67'(b8.out_valid), 67'd0);
        end
        check_eq("w8_queue_empty", 67'(exp8_q.size()), 67'd0);

        // Wait for the random instances, bounded.
        cyc = 0;
        while ((g_rnd[0].got < NOPS || g_rnd[1].got < NOPS || g_rnd[2].got < NOPS)
               && cyc < 60000) begin
            @(posedge clk);
            cyc++;
        end
        check_eq("rnd_done_w16_d1",  67'(g_rnd[0].got), 67'(NOPS));
        check_eq("rnd_done_w16_d16", 67'(g_rnd[1].got), 67'(NOPS));
        check_eq("rnd_done_w12_d4",  67'(g_rnd[2].got), 67'(NOPS));
        check_eq("rnd_queue_w16_d1",  67'(g_rnd[0].exp_q.size()), 67'd0);
        check_eq("rnd_queue_w16_d16", 67'(g_rnd[1].exp_q.size()), 67'd0);
        check_eq("rnd_queue_w12_d4",  67'(g_rnd[2].exp_q.size()), 67'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
